// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the PWM bank.
package pwm_pkg;
  localparam int MIN_PERIOD = 2;
  localparam int DUTY_W     = 32;

  typedef logic [DUTY_W-1:0] duty_t;

  // Host-visible shadow plus the copy the comparator actually uses.
  typedef struct packed {
    duty_t shd;
    duty_t act;
  } duty_regs_t;

  // A period shorter than MIN_PERIOD cannot produce a distinct wrap.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty, write decode, load bypass, compare, output flop.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CH     = 0,
  parameter int CNT_W  = 16,
  parameter int WR_W   = 2,
  parameter bit INVERT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             wr_en_i,
  input  logic [WR_W-1:0]  wr_ch_i,
  input  logic [CNT_W-1:0] wr_duty_i,
  output logic             pwm_o
);
  duty_regs_t regs_q, regs_d;
  logic       wr_hit, on, pwm_q;

  assign wr_hit = wr_en_i && (wr_ch_i == WR_W'(CH));

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d.shd = duty_t'(wr_duty_i);
    // A write landing on the load cycle goes straight into the active copy.
    if (!en_i)       regs_d.act = regs_q.shd;
    else if (load_i) regs_d.act = wr_hit ? duty_t'(wr_duty_i) : regs_q.shd;
  end

  assign on = en_i && (duty_t'(cnt_i) < regs_q.act);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      pwm_q  <= INVERT;
    end else begin
      regs_q <= regs_d;
      pwm_q  <= on ^ INVERT;
    end
  end

  assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM with a shared period counter and glitch-free, period-aligned updates.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter  int N_CH           = 3,
  parameter  int CNT_W          = 16,
  parameter  int DEFAULT_PERIOD = 10000,
  parameter  bit INVERT         = 1'b1,
  localparam int WR_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             wr_en,
  input  logic [WR_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  output logic [N_CH-1:0]  pwm_out,
  output logic             period_tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, per_cl;
  logic             load, tick_q;

  assign per_cl = CNT_W'(clamp_period(32'(period)));
  assign load   = en && (cnt_q == per_q - CNT_W'(1));

  // Disabled behaves like a permanent load point with the counter parked at 0.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    per_d = per_q;
    if (!en || load) begin
      cnt_d = '0;
      per_d = per_cl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      per_q  <= CNT_W'(DEFAULT_PERIOD);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      tick_q <= en && (cnt_q == '0);
    end
  end

  assign period_tick = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .CH     (i),
      .CNT_W  (CNT_W),
      .WR_W   (WR_W),
      .INVERT (INVERT)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .load_i    (load),
      .cnt_i     (cnt_q),
      .wr_en_i   (wr_en),
      .wr_ch_i   (wr_ch),
      .wr_duty_i (wr_duty),
      .pwm_o     (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank (N_CH=3, CNT_W=16, DEFAULT_PERIOD=10000, INVERT=1).
module tb_pwm_bank;
  localparam int N_CH  = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, en, wr_en;
  logic [CNT_W-1:0] period, wr_duty;
  logic [1:0]       wr_ch;
  logic [N_CH-1:0]  pwm_out;
  logic             period_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_bank #(
    .N_CH           (N_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (10000),
    .INVERT         (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period      (period),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output at window cycle k of a p-cycle period; active-low outputs.
  function automatic logic [2:0] exp_pwm(input int k, input int p, input int d0, input int d1, input int d2);
    logic [2:0] on;
    on[0] = (k < d0) && (k < p);
    on[1] = (k < d1) && (k < p);
    on[2] = (k < d2) && (k < p);
    return ~on;
  endfunction

  // Observe one full period starting on its tick cycle; optional write at cycle wk.
  task automatic window(input string tag, input int p, input int d0, input int d1, input int d2,
                        input int wk, input logic [1:0] wch, input int wd);
    int   bad   = 0;
    int   ticks = 0;
    logic t0    = 1'b0;
    for (int k = 0; k < p; k++) begin
      if (pwm_out !== exp_pwm(k, p, d0, d1, d2)) bad++;
      if (period_tick === 1'b1) ticks++;
      if (k == 0) t0 = period_tick;
      if (k == wk) begin
        wr_en   = 1'b1;
        wr_ch   = wch;
        wr_duty = CNT_W'(wd);
      end
      step();
      wr_en = 1'b0;
    end
    chk({tag, "_shape"}, bad, 0);
    chk({tag, "_tick0"}, 32'(t0), 1);
    chk({tag, "_ticks"}, ticks, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; period = 16'd10;
    #2;
    chk("rst_pwm", 32'(pwm_out), 32'h7);
    chk("rst_tick", 32'(period_tick), 0);
    repeat (2) step();
    rst = 1'b0;
    step(); step();
    chk("idle_pwm", 32'(pwm_out), 32'h7);
    chk("idle_tick", 32'(period_tick), 0);

    wr_en = 1'b1;
    wr_ch = 2'd0; wr_duty = 16'd0;  step();
    wr_ch = 2'd1; wr_duty = 16'd3;  step();
    wr_ch = 2'd2; wr_duty = 16'd10; step();
    wr_en = 1'b0;
    step(); step();
    chk("dis_pwm", 32'(pwm_out), 32'h7);

    en = 1'b1;
    step();
    window("w1", 10, 0, 3, 10, -1, 2'd0, 0);
    window("w2", 10, 0, 3, 10, -1, 2'd0, 0);
    window("w3_midwr", 10, 0, 3, 10, 3, 2'd1, 7);
    window("w4_loadwr", 10, 0, 7, 10, 8, 2'd1, 5);
    period = 16'd4;
    window("w5_p10", 10, 0, 5, 10, -1, 2'd0, 0);
    period = 16'd0;
    window("w6_p4", 4, 0, 5, 10, -1, 2'd0, 0);
    period = 16'd10;
    window("w7_p2", 2, 0, 5, 10, -1, 2'd0, 0);
    window("w8_badch", 10, 0, 5, 10, 3, 2'd3, 1);
    window("w9", 10, 0, 5, 10, -1, 2'd0, 0);

    repeat (5) step();
    en = 1'b0;
    step();
    chk("endrop_pwm", 32'(pwm_out), 32'h7);
    chk("endrop_tick", 32'(period_tick), 0);
    step();
    chk("endis_pwm", 32'(pwm_out), 32'h7);
    en = 1'b1;
    step();
    window("w10_reen", 10, 0, 5, 10, -1, 2'd0, 0);

    repeat (4) step();
    chk("prerst_pwm", 32'(pwm_out), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pwm", 32'(pwm_out), 32'h7);
    chk("rst_async_tick", 32'(period_tick), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    window("w11_postrst", 10000, 0, 0, 0, 0, 2'd2, 10000);
    chk("postrst_tick", 32'(period_tick), 1);
    chk("postrst_pwm", 32'(pwm_out), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_bank.md
# pwm_bank

Multi-channel, parametrised PWM generator for driving LED colour channels and similar loads. All channels share one period counter; each channel has its own duty. Duty and period are programmed in raw clock counts and take effect only at a period boundary, so duty updates never glitch the output. It replaces the single-channel percentage-based PWM in the LED path. The optional output inversion drives common-anode LEDs directly.

## Interface
Parameters:
- `N_CH`, 3, number of PWM channels (≥1)
- `CNT_W`, 16, width of the counter, period and duty values
- `DEFAULT_PERIOD`, 10000, active period after reset; must satisfy 2 ≤ value < 2^CNT_W
- `INVERT`, 1, 1 = output low when "on" (common-anode LED), 0 = output high when "on"

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `en`  in  1  global enable
- `period`  in  CNT_W  requested period in clocks; sampled only at load points
- `wr_en`  in  1  duty write strobe; always accepted, no backpressure
- `wr_ch`  in  $clog2(N_CH) (min 1)  channel index for the write
- `wr_duty`  in  CNT_W  duty for that channel, in clocks "on" per period
- `pwm_out`  out  N_CH  per-channel PWM output (polarity set by INVERT)
- `period_tick`  out  1  one-cycle pulse at the start of each period

## Operation
- **State per channel:** `duty_shd` (shadow, written by the host) and `duty_act` (used for compare).
- **Shared state:** `period_act` and counter `cnt`.
- **Write:** when `wr_en`=1 and `wr_ch` < N_CH, `duty_shd[wr_ch]` ← `wr_duty`. A write with `wr_ch` ≥ N_CH is ignored.
- **Load point:** the cycle with `en`=1 and `cnt` == `period_act`−1. On that edge:
  - `cnt` ← 0
  - every `duty_act` ← its shadow
  - `period_act` ← clamp(`period`)
  - Otherwise `cnt` ← `cnt`+1.
- **Clamp:** `period` < 2 is treated as 2. There is no other arithmetic: no multiply and no percentage.
- **Write on a load-point cycle:** the new `wr_duty` bypasses straight into `duty_act`. The value being written wins.
- **Disabled (`en`=0):**
  - `cnt` is held at 0.
  - `duty_act` and `period_act` reload from shadow and clamp(`period`) every cycle.
  - Outputs are at the inactive level and `period_tick`=0.
  - Writes are still accepted.
- **Enabling:** asserting `en` starts the counter at 0 with current values. There is no stale period.
- **Compare:** channel i is "on" when `en` && (`cnt` < `duty_act[i]`).
  - `duty_act` = 0 → always off.
  - `duty_act` ≥ `period_act` → on for the whole period, with no gap at the wrap.
- **Output level:** `pwm_out[i]` = on XOR INVERT.
- **`period_tick`:** asserted for the one cycle in which `cnt`==0 following a load point taken while enabled.
- **Reset:**
  - `cnt`=0, all `duty_shd`/`duty_act`=0, `period_act`=DEFAULT_PERIOD.
  - `pwm_out` = {N_CH{INVERT}} (inactive), `period_tick`=0.
  - Reset mid-period aborts immediately. No partial period completes.

## Timing
- `pwm_out` and `period_tick` are registered. `pwm_out[i]` in cycle t+1 reflects the compare of `cnt`(t) and `duty_act`(t).
- `period_tick` rises in the same cycle that `pwm_out` first shows the compare for `cnt`=0.
- A period is exactly `period_act` cycles. The "on" time is min(`duty_act`, `period_act`) cycles.
- Write-to-effect latency: from the next load point. This is 1 to `period_act` cycles, or 2 cycles to output while disabled.
- Dropping `en`: outputs go inactive on the next edge.
- Raising `en`: the first compare (`cnt`=0) appears at the output one cycle after `en` is sampled high.
- Reset assertion forces outputs inactive asynchronously. Release is synchronous to `clk`.

## Structure
- **Package `pwm_pkg`:**
  - `MIN_PERIOD` = 2
  - function `clamp_period`
  - typedef for the per-channel register pair (shadow/active)
- **Sub-module `pwm_channel`**, instantiated N_CH times. It holds the shadow/active duty, the write decode match, the bypass, the compare and the output flop.
- **Top `pwm_bank`:** holds `cnt`, `period_act`, the load-point logic and `period_tick`.

## Test plan
- Reset with INVERT=1, N_CH=3. Expected: `pwm_out`=3'b111 during reset and after release while `en`=0; `period_tick`=0.
- `period`=10, duties 0/3/10 on ch0/1/2, then `en`=1. Expected each period:
  - ch0 never on
  - ch1 on for exactly 3 cycles starting with `period_tick`
  - ch2 on for all 10 cycles
  - `period_tick` every 10 cycles
- Mid-period write, ch1 duty 3→7 at `cnt`=4. Expected: the current period still shows 3 "on" cycles; the next period shows 7. Also write exactly on the `cnt`=9 cycle and confirm the new value applies in the next period.
- `period` changed 10→4 mid-period, then to 0. Expected: the current period completes at 10; the next is 4 cycles; after that the period is 2 cycles (clamped).
- Write with `wr_ch`=3 (N_CH=3). Expected: no channel changes. Then `en` drop mid-period: outputs are inactive on the next edge and `cnt` is 0; re-enable starts a fresh period with `period_tick`.
- Assert `rst` at `cnt`=5 with ch2 on. Expected: outputs inactive immediately; after release all duties are 0 and `period_act`=DEFAULT_PERIOD.
